uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing the UART TX path, legal range 2..8.
REQ-002 Parameter EOM_BYTE, default 8'h0A: end-of-message byte; after it is sent, the arbiter releases the grant.
REQ-003 Parameter HOLD_TIMEOUT, default 1024: number of idle cycles an owner may stall mid-message before the grant is revoked, legal range 2..65535.
REQ-004 clk_50  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester byte-valid.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 req_ready  output  NUM_REQ  per-requester byte accept; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 tx_start  output  1  one-cycle pulse to the UART transmitter.
REQ-010 tx_data  output  8  byte for the transmitter; stable from tx_start until tx_busy falls.
REQ-011 tx_busy  input  1  transmitter busy; rises after tx_start and falls when the stop bit ends.
REQ-012 grant  output  NUM_REQ  one-hot current owner; all zero when unowned.
REQ-013 timeout_flag  output  1  one-cycle pulse when a grant is revoked by HOLD_TIMEOUT.

Function
REQ-014 The FSM states shall be IDLE, LOAD, START, WAIT_ACK and WAIT_DONE.
REQ-015 IDLE: if any req_valid bit is high, the arbiter shall pick an owner round-robin, starting at the requester after the last owner (requester 0 after reset), register it into grant, and go to LOAD next cycle.
REQ-016 LOAD: req_ready[owner] shall equal req_valid[owner] combinationally; on a transfer, the byte shall be latched into tx_data and the FSM shall go to START. All other req_ready bits shall be 0 in every state.
REQ-017 LOAD: the idle counter shall increment each cycle req_valid[owner] is low. When it reaches HOLD_TIMEOUT-1, the arbiter shall clear grant, pulse timeout_flag and return to IDLE.
REQ-018 START: tx_start shall be 1 for exactly this cycle; the FSM then goes to WAIT_ACK.
REQ-019 WAIT_ACK: the FSM shall stay until tx_busy is 1, then go to WAIT_DONE.
REQ-020 WAIT_DONE: the FSM shall stay until tx_busy is 0. Then, if the sent byte equals EOM_BYTE, it shall clear grant and go to IDLE; otherwise it shall clear the idle counter and go to LOAD.
REQ-021 Latency: req_valid high in IDLE at edge k gives grant at k+1, req_ready at k+1 if valid holds, and tx_start at k+2.
REQ-022 Grant shall be held for a whole message; requests from non-owners shall not preempt it.
REQ-023 After release, the last owner shall have the lowest priority; with NUM_REQ=4, the priority order after owner 3 shall be 0,1,2,3 (wrap-around).
REQ-024 If several requesters assert req_valid in the same IDLE cycle, exactly one shall be granted, per REQ-015.
REQ-025 The idle counter shall be 16 bits, saturating, and cleared on entering LOAD.
REQ-026 tx_data shall change only on a LOAD transfer.

Reset
REQ-027 While rst is high, the block shall force: state IDLE, grant 0, last owner NUM_REQ-1, tx_start 0, tx_data 8'h00, req_ready 0, timeout_flag 0, idle counter 0.
REQ-028 rst asserted mid-message shall abort without emitting tx_start; the first cycle after rst falls shall be IDLE.

Structure
REQ-029 Package uart_arb_pkg shall hold the FSM state encoding, the EOM_BYTE default and the HOLD_TIMEOUT default.
REQ-030 The round-robin pick shall be a combinational sub-module rr_pick taking (req, last_owner) and returning a one-hot result; it shall be instantiated once.

Verification
REQ-031 Single requester 1 sends 8'h48, 8'h0A with tx_busy high for 10 cycles after each tx_start: expect two tx_start pulses with tx_data 8'h48 then 8'h0A, then grant back to 0.
REQ-032 Requesters 0 and 2 both valid in IDLE after reset: expect grant=4'b0001 first; after its EOM completes, expect grant=4'b0100.
REQ-033 Owner 0 mid-message while requester 3 raises valid: expect grant to stay 4'b0001 until EOM, and req_ready[3] to stay 0 throughout.
REQ-034 Owner drops valid after a non-EOM byte with HOLD_TIMEOUT=16: expect timeout_flag pulse 16 cycles after entering LOAD, grant 0, and next arbitration starting after that owner.
REQ-035 rst pulsed during WAIT_DONE: expect next cycle state IDLE, grant 0, no tx_start, and requester 0 winning when all requesters are valid.
REQ-036 Owner 3 completes a message, then all requesters are valid: expect grant order 0,1,2,3 across successive messages.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART TX arbiter:
//   - arb_state_t      : FSM state encoding
//   - EOM_BYTE_DEFAULT : default end-of-message byte
//   - HOLD_TIMEOUT_DEFAULT : default owner stall limit, in cycles
//   - onehot_to_idx    : converts a one-hot vector (up to MAX_REQ bits) to an index
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_t;

    localparam logic [7:0] EOM_BYTE_DEFAULT     = 8'h0A;
    localparam int         HOLD_TIMEOUT_DEFAULT = 1024;

    // Callers zero-extend narrower vectors to MAX_REQ bits.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans the request vector starting at
// the requester just after last_owner and wrapping around, so the previous
// owner is considered last.
// Ports:
//   req        in  [NUM_REQ-1:0]  request vector
//   last_owner in  [IDX_W-1:0]    index of the previous owner
//   pick       out [NUM_REQ-1:0]  one-hot winner, all zero when no request
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick
);

    int   idx;
    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_owner) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte requesters. An owner is
// chosen round-robin and keeps the grant for a whole message, which ends
// when EOM_BYTE has been sent or when the owner stalls for HOLD_TIMEOUT
// cycles while the arbiter is waiting for its next byte.
//
// Ports:
//   clk_50        in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   req_valid     in   [NUM_REQ-1:0]   per-requester byte valid
//   req_data      in   [8*NUM_REQ-1:0] per-requester byte, requester i at [8i+7:8i]
//   req_ready     out  [NUM_REQ-1:0]   per-requester byte accept (owner only)
//   tx_start      out  one-cycle start pulse to the transmitter
//   tx_data       out  [7:0] byte for the transmitter, held until next transfer
//   tx_busy       in   transmitter busy
//   grant         out  [NUM_REQ-1:0]   one-hot owner, zero when unowned
//   timeout_flag  out  one-cycle pulse when the owner is dropped for stalling
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | no owner; arbitrate as soon as any requester is valid
// ST_LOAD      | owner holds grant; accept its next byte, count stall cycles
// ST_START     | tx_start is high for this single cycle
// ST_WAIT_ACK  | wait for the transmitter to report busy
// ST_WAIT_DONE | wait for the byte to finish; release on EOM_BYTE
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ      = 4,
    parameter logic [7:0] EOM_BYTE     = EOM_BYTE_DEFAULT,
    parameter int         HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT
) (
    input  logic                   clk_50,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   timeout_flag
);

    localparam int          IDX_W        = $clog2(NUM_REQ);
    localparam logic [15:0] TIMEOUT_LAST = 16'(HOLD_TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 timeout_flag_q, timeout_flag_d;
    logic [15:0]          idle_cnt_q, idle_cnt_d;

    logic [NUM_REQ-1:0]   pick;
    logic                 owner_valid;
    logic [7:0]           owner_byte;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_owner (last_owner_q),
        .pick       (pick)
    );

    // Owner's valid and byte, selected by the one-hot grant.
    always_comb begin
        owner_valid = |(req_valid & grant_q);
        owner_byte  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_byte = req_data[8*i +: 8];
            end
        end
    end

    // Combinational so the owner's byte moves in the same cycle valid is seen.
    // rst gates it because state_q still holds its old value during the
    // first reset cycle.
    assign req_ready = (state_q == ST_LOAD && !rst) ? (grant_q & req_valid) : '0;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_owner_d   = last_owner_q;
        tx_data_d      = tx_data_q;
        idle_cnt_d     = idle_cnt_q;
        timeout_flag_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d      = pick;
                    last_owner_d = IDX_W'(onehot_to_idx(MAX_REQ'(pick)));
                    idle_cnt_d   = '0;
                    state_d      = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (owner_valid) begin
                    tx_data_d = owner_byte;
                    state_d   = ST_START;
                end else if (idle_cnt_q == TIMEOUT_LAST) begin
                    grant_d        = '0;
                    timeout_flag_d = 1'b1;
                    state_d        = ST_IDLE;
                end else if (idle_cnt_q != CNT_MAX) begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end

            ST_START: begin
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (tx_data_q == EOM_BYTE) begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idle_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the pulse lines up exactly with the START state.
        tx_start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            last_owner_q   <= IDX_W'(NUM_REQ - 1);
            tx_data_q      <= 8'h00;
            tx_start_q     <= 1'b0;
            timeout_flag_q <= 1'b0;
            idle_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_owner_q   <= last_owner_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            timeout_flag_q <= timeout_flag_d;
            idle_cnt_q     <= idle_cnt_d;
        end
    end

    assign grant        = grant_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int HOLD     = 16;
    localparam int BUSY_LEN = 10;

    logic                 clk_50 = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [NUM_REQ-1:0]   grant;
    logic                 timeout_flag;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .EOM_BYTE     (8'h0A),
        .HOLD_TIMEOUT (HOLD)
    ) dut (
        .clk_50       (clk_50),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant        (grant),
        .timeout_flag (timeout_flag)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] exp_grant;
    } rr_vec_t;

    rr_vec_t    vecs [9];

    int         n_checks;
    int         n_fail;
    int         cyc;
    int         n_start;
    int         n_timeout;
    int         busy_cnt;
    int         fall_cyc;
    int         timeout_cyc;
    int         bad_ready;
    logic [7:0] hold_byte;
    logic [3:0] pend;
    logic [7:0] sent [$];
    logic [7:0] rq [4][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sent_at(input int i);
        if (i < sent.size()) return 32'(sent[i]);
        return 32'hDEAD;
    endfunction

    // One clock cycle: observe outputs, model the transmitter, model the
    // requesters (queues drained on accepted transfers), then drive inputs.
    task automatic step();
        @(negedge clk_50);
        cyc++;
        if (tx_start === 1'b1) begin
            n_start++;
            sent.push_back(tx_data);
        end
        if (timeout_flag === 1'b1) begin
            n_timeout++;
            timeout_cyc = cyc;
        end
        if (rst) begin
            tx_busy  = 1'b0;
            busy_cnt = 0;
        end else if (tx_start) begin
            tx_busy   = 1'b1;
            busy_cnt  = BUSY_LEN;
            hold_byte = tx_data;
        end else if (busy_cnt > 0) begin
            chk("tx_data_stable", 32'(tx_data), 32'(hold_byte));
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy  = 1'b0;
                fall_cyc = cyc;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]       = (rq[i].size() > 0);
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
        #1;
        pend = req_valid & req_ready;
        if ((req_ready & ~(grant & req_valid)) != '0) bad_ready++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_queues();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_grant(input bit nonzero, input int budget, input string name);
        int n;
        n = 0;
        while (((grant != '0) != nonzero) && n < budget) begin
            step();
            n++;
        end
        chk(name, {31'd0, (grant != '0)}, {31'd0, nonzero});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int t0;
        int n;
        int hold_bad;
        logic ready3;

        vecs[0] = '{4'b1111, 4'b0001};
        vecs[1] = '{4'b0000, 4'b0010};
        vecs[2] = '{4'b0001, 4'b0100};
        vecs[3] = '{4'b0000, 4'b1000};
        vecs[4] = '{4'b0000, 4'b0001};
        vecs[5] = '{4'b0110, 4'b0010};
        vecs[6] = '{4'b1000, 4'b0100};
        vecs[7] = '{4'b0001, 4'b1000};
        vecs[8] = '{4'b0000, 4'b0001};

        n_checks = 0; n_fail = 0; cyc = 0; n_start = 0; n_timeout = 0;
        busy_cnt = 0; fall_cyc = 0; timeout_cyc = 0; bad_ready = 0;
        hold_byte = 8'h00; pend = '0;
        rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;

        // Reset with a requester already valid
        rq[0].push_back(8'h0A);
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_timeout", 32'(timeout_flag), 32'h0);
        clear_queues();
        step();
        rst = 1'b0;
        step();
        step();
        chk("idle_grant", 32'(grant), 32'h0);

        // Single requester 1, two-byte message, exact latency
        s0 = n_start;
        sent.delete();
        rq[1].push_back(8'h48);
        rq[1].push_back(8'h0A);
        step();
        chk("lat_grant_k", 32'(grant), 32'h0);
        step();
        chk("lat_grant_k1", 32'(grant), 32'b0010);
        chk("lat_ready_k1", 32'(req_ready), 32'b0010);
        chk("lat_start_k1", 32'(tx_start), 32'h0);
        step();
        chk("lat_start_k2", 32'(tx_start), 32'h1);
        chk("lat_data_k2", 32'(tx_data), 32'h48);
        step();
        chk("start_one_cycle", 32'(tx_start), 32'h0);
        wait_grant(1'b0, 100, "msg1_release");
        chk("msg1_starts", 32'(n_start - s0), 32'd2);
        chk("msg1_byte0", sent_at(0), 32'h48);
        chk("msg1_byte1", sent_at(1), 32'h0A);

        // Requesters 0 and 2 together after reset
        do_reset();
        rq[0].push_back(8'h11); rq[0].push_back(8'h0A);
        rq[2].push_back(8'h22); rq[2].push_back(8'h0A);
        wait_grant(1'b1, 10, "two_req_wait_a");
        chk("two_req_first", 32'(grant), 32'b0001);
        wait_grant(1'b0, 200, "two_req_rel_a");
        wait_grant(1'b1, 10, "two_req_wait_b");
        chk("two_req_second", 32'(grant), 32'b0100);
        wait_grant(1'b0, 200, "two_req_rel_b");

        // Owner 0 mid-message, requester 3 must not preempt
        sent.delete();
        rq[0].push_back(8'h31); rq[0].push_back(8'h32); rq[0].push_back(8'h0A);
        wait_grant(1'b1, 10, "hold_wait");
        chk("hold_owner", 32'(grant), 32'b0001);
        rq[3].push_back(8'h0A);
        hold_bad = 0;
        ready3   = 1'b0;
        n        = 0;
        while (grant != '0 && n < 300) begin
            step();
            n++;
            if (grant != '0 && grant != 4'b0001) hold_bad++;
            ready3 |= req_ready[3];
        end
        chk("hold_release", 32'(grant), 32'h0);
        chk("hold_no_preempt", 32'(hold_bad), 32'h0);
        chk("hold_ready3_low", 32'(ready3), 32'h0);
        chk("hold_byte0", sent_at(0), 32'h31);
        chk("hold_byte1", sent_at(1), 32'h32);
        chk("hold_byte2", sent_at(2), 32'h0A);
        wait_grant(1'b1, 10, "req3_wait");
        chk("req3_grant", 32'(grant), 32'b1000);
        wait_grant(1'b0, 200, "req3_release");

        // Round-robin table, continuing from owner 3
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (vecs[v].mask[i]) rq[i].push_back(8'h0A);
            end
            wait_grant(1'b1, 10, $sformatf("rr_wait%0d", v));
            chk($sformatf("rr_vec%0d", v), 32'(grant), 32'(vecs[v].exp_grant));
            wait_grant(1'b0, 200, $sformatf("rr_rel%0d", v));
        end

        // Owner 2 stalls after a non-EOM byte
        do_reset();
        t0 = n_timeout;
        rq[2].push_back(8'h55);
        wait_grant(1'b1, 10, "to_wait");
        chk("to_owner", 32'(grant), 32'b0100);
        wait_grant(1'b0, 200, "to_release");
        chk("to_flag_with_release", 32'(timeout_flag), 32'h1);
        chk("to_delay", 32'(timeout_cyc - fall_cyc), 32'd17);
        step();
        chk("to_pulse_width", 32'(timeout_flag), 32'h0);
        chk("to_count", 32'(n_timeout - t0), 32'd1);
        rq[0].push_back(8'h0A);
        rq[3].push_back(8'h0A);
        wait_grant(1'b1, 10, "to_next_wait");
        chk("to_next_owner", 32'(grant), 32'b1000);
        wait_grant(1'b0, 200, "to_next_rel");
        wait_grant(1'b1, 10, "to_next2_wait");
        chk("to_next2_owner", 32'(grant), 32'b0001);
        wait_grant(1'b0, 200, "to_next2_rel");

        // Reset during WAIT_DONE
        rq[1].push_back(8'h61); rq[1].push_back(8'h0A);
        wait_grant(1'b1, 10, "mrst_wait");
        chk("mrst_owner", 32'(grant), 32'b0010);
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        step(); step(); step();
        chk("mrst_busy", 32'(tx_busy), 32'h1);
        s0 = n_start;
        rst = 1'b1;
        clear_queues();
        step();
        chk("mrst_grant", 32'(grant), 32'h0);
        chk("mrst_tx_start", 32'(tx_start), 32'h0);
        chk("mrst_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) rq[i].push_back(8'h0A);
        step();
        chk("mrst_idle_grant", 32'(grant), 32'h0);
        step();
        chk("mrst_first_owner", 32'(grant), 32'b0001);
        chk("mrst_no_start", 32'(n_start - s0), 32'd0);
        for (int r = 0; r < NUM_REQ; r++) begin
            wait_grant(1'b1, 10, "drain_wait");
            wait_grant(1'b0, 200, "drain_rel");
        end

        chk("ready_only_owner", 32'(bad_ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
